// File: rtl/if_id_skid_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_buf_pkg
// Description : Shared pipeline definitions for the fetch/decode boundary.
//               Holds field widths, the reset/idle constants, the packed
//               {pc, inst} beat type, and the occupancy state encoding used
//               by the IF/ID skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_skid_buf_pkg;

  // Field widths of a fetch beat.
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  // Canonical RISC-V NOP (addi x0,x0,0), shown to decode when nothing is held.
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  // First fetch address after reset; shared with fetch and verification.
  localparam logic [PC_W-1:0] RESET_PC = 32'h8000_0000;

  // One beat crossing the IF/ID boundary.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_id_beat_t;

  // Buffer state; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage : if_id_skid_buf_pkg
`default_nettype wire

// File: rtl/if_id_skid_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_buf_if
// Description : Bundle of the fetch-side and decode-side handshake signals
//               around the IF/ID skid buffer.
//   Fetch side  : in_valid, in_ready, in_pc, in_inst, flush
//   Decode side : out_valid, out_ready, out_pc, out_inst
//   Debug       : occupancy (beats currently held, 0..2)
//   Modports    : master - environment (fetch + decode + redirect source)
//                 slave  - the skid buffer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_skid_buf_if #(
  parameter int PC_W   = if_id_skid_buf_pkg::PC_W,
  parameter int INST_W = if_id_skid_buf_pkg::INST_W
);

  // Fetch -> buffer
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              flush;

  // Buffer -> decode
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;

  // Debug / performance
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, occupancy
  );

endinterface : if_id_skid_buf_if
`default_nettype wire

// File: rtl/if_id_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_buf
// Description : Two-entry skid buffer / pipeline register between fetch and
//               decode. Beats {pc, inst} are accepted on in_valid & in_ready
//               and presented to decode in strict FIFO order. in_ready only
//               depends on registered occupancy, so the decode stall path is
//               cut from fetch. A flush discards every held beat and any beat
//               arriving on the same edge.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - if_id_skid_buf_if.slave (fetch/decode handshakes,
//                        flush, occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_buf
  import if_id_skid_buf_pkg::*;
#(
  parameter int                PC_W     = if_id_skid_buf_pkg::PC_W,
  parameter int                INST_W   = if_id_skid_buf_pkg::INST_W,
  parameter logic [INST_W-1:0] NOP_INST = if_id_skid_buf_pkg::NOP_INST
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  if_id_skid_buf_if.slave   bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  occ_state_e        r_state;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [PC_W-1:0]   r_pc   [2];
  logic [INST_W-1:0] r_inst [2];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Both flags come straight from the state register: no path from
  // out_ready or in_valid reaches in_ready.
  assign w_in_ready  = (r_state != OCC_FULL);
  assign w_out_valid = (r_state != OCC_EMPTY);

  assign w_push = bus.in_valid & w_in_ready;
  assign w_pop  = w_out_valid  & bus.out_ready;

  // --------------------------------------------------------------------------
  // Storage, pointers and occupancy state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= OCC_EMPTY;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_pc[0]   <= '0;
      r_pc[1]   <= '0;
      r_inst[0] <= NOP_INST;
      r_inst[1] <= NOP_INST;
    end else if (bus.flush) begin
      // Redirect wins over everything: drop held beats and the beat being
      // handed over this edge. Upstream still sees its handshake complete,
      // and a beat decode took this edge is decode's to ignore. Entry
      // contents are left alone; they are unreachable until rewritten.
      r_state  <= OCC_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]   <= bus.in_pc;
        r_inst[r_wr_ptr] <= bus.in_inst;
        r_wr_ptr         <= ~r_wr_ptr;
      end

      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case (r_state)
        OCC_EMPTY: begin
          // Nothing to pop while empty.
          if (w_push) begin
            r_state <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          // push & pop together keeps one beat; the new beat becomes head
          // because rd_ptr advances onto the slot just written.
          if (w_push && !w_pop) begin
            r_state <= OCC_FULL;
          end else if (w_pop && !w_push) begin
            r_state <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          // in_ready is low, so only a pop can change state.
          if (w_pop) begin
            r_state <= OCC_ONE;
          end
        end
        default: begin
          r_state <= OCC_EMPTY;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;

  // Idle decode sees pc 0 and a NOP rather than stale entry contents.
  assign bus.out_pc    = w_out_valid ? r_pc[r_rd_ptr]   : '0;
  assign bus.out_inst  = w_out_valid ? r_inst[r_rd_ptr] : NOP_INST;

  assign bus.occupancy = r_state;

endmodule : if_id_skid_buf
`default_nettype wire

// File: tb/tb_if_id_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_skid_buf
// Description : Directed plus random stimulus for if_id_skid_buf. A queue of
//               expected beats is filled when a beat is handed to the buffer
//               and drained when decode takes the head; every cycle the head,
//               handshake flags and occupancy are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_buf;
  import if_id_skid_buf_pkg::*;

  logic clk;
  logic rst_n;

  if_id_skid_buf_if bus ();

  if_id_skid_buf u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors    = 0;
  int          checks    = 0;
  int          delivered = 0;
  logic        hs_in;
  if_id_beat_t q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare DUT against the model at the negative edge, then advance the model
  // by what the coming rising edge will do, and return just after that edge.
  task automatic cycle();
    logic pop;
    @(negedge clk);
    chk("occupancy", 64'(bus.occupancy), 64'(q.size()));
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready",  64'(bus.in_ready),  64'(q.size() != 2));
    if (q.size() != 0) begin
      chk("out_pc",   64'(bus.out_pc),   64'(q[0].pc));
      chk("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
    end else begin
      chk("idle_pc",   64'(bus.out_pc),   64'd0);
      chk("idle_inst", 64'(bus.out_inst), 64'(NOP_INST));
    end
    pop   = (q.size() != 0) && bus.out_ready;
    hs_in = bus.in_valid && (q.size() != 2);
    if (pop) delivered++;
    if (bus.flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (hs_in) q.push_back('{pc: bus.in_pc, inst: bus.in_inst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  // Hard stop in case the clock process or a loop runs away.
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          cyc;
    logic [31:0] next_pc;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- reset state, single beat pass-through ----
    cycle();
    drive(1'b1, RESET_PC, 32'h0000_0297, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();                               // beat visible, consumed
    cycle();                               // empty again, NOP shown
    chk("single_delivered", 64'(delivered), 64'd1);

    // ---- fill to two, hold a third, then drain ----
    drive(1'b1, 32'h8000_0000, 32'h1111_0000, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h8000_0004, 32'h1111_0004, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h8000_0008, 32'h1111_0008, 1'b0, 1'b0);
    repeat (3) cycle();                    // refused while full
    chk("full_occupancy", 64'(bus.occupancy), 64'd2);
    chk("full_in_ready",  64'(bus.in_ready),  64'd0);
    bus.out_ready = 1'b1;
    cycle();                               // pop ...00, third still refused
    cycle();                               // pop ...04, third accepted
    bus.in_valid = 1'b0;
    cycle();                               // pop ...08
    cycle();
    chk("drain_delivered", 64'(delivered), 64'd4);

    // ---- steady stream at occupancy 1 ----
    base = delivered;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, RESET_PC + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("stream_delivered", 64'(delivered - base), 64'd8);

    // ---- flush with a colliding push ----
    drive(1'b1, 32'h8000_0010, 32'h2222_0010, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h8000_0014, 32'h2222_0014, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h8000_0018, 32'h2222_0018, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();                               // empty, ready after flush
    drive(1'b1, 32'h8000_0100, 32'h2222_0100, 1'b1, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    cycle();                               // head must be ...100
    cycle();

    // ---- asynchronous reset while full ----
    drive(1'b1, 32'h8000_0020, 32'h3333_0020, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h8000_0024, 32'h3333_0024, 1'b0, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_occupancy", 64'(bus.occupancy), 64'd0);
    chk("arst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("arst_out_inst",  64'(bus.out_inst),  64'(NOP_INST));
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, RESET_PC, 32'h0000_0297, 1'b1, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // ---- random traffic with occasional flushes ----
    base    = delivered;
    next_pc = RESET_PC;
    cyc     = 0;
    while ((delivered - base) < 1000 && cyc < 8000) begin
      drive(1'($urandom_range(0, 1)), next_pc, $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
      cycle();
      if (hs_in) next_pc = next_pc + 32'd4;
      cyc++;
    end
    chk("random_budget", 64'((delivered - base) >= 1000), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_if_id_skid_buf
`default_nettype wire
